// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encodings, round count and GF(2^8) helpers
// used by the inverse-cipher datapath.
package aes_pkg;

    localparam int unsigned NR       = 10;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned BLOCK_W  = 128;
    localparam int unsigned KSEL_W   = 4;
    localparam int unsigned STATE_W  = 3;
    localparam logic [7:0]  POLY     = 8'h1b;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ISR  = 3'd2,
        S_ISB  = 3'd3,
        S_ARK  = 3'd4,
        S_IMC  = 3'd5,
        S_DONE = 3'd6
    } aes_state_e;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] mul11(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] mul13(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] mul14(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    // One column through the circulant [0e 0b 0d 09]; byte 0 is col[31:24]
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3),
                mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3),
                mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3),
                mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3)};
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: 256-entry combinational lookup, one byte in, one byte out.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] din_i,
    output logic [BYTE_W-1:0] dout_o
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign dout_o = INV_SBOX[din_i];

endmodule

// File: rtl/aes_decryptor.sv
// Iterative AES-128 inverse cipher: one transform per clock, round keys
// fetched externally by index, plaintext presented with a one-cycle pulse.
module aes_decryptor
    import aes_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                En,
    input  logic [BLOCK_W-1:0]  CT,
    input  logic [BLOCK_W-1:0]  Key,
    output logic [KSEL_W-1:0]   SelKey,
    output logic [BLOCK_W-1:0]  PT,
    output logic                Ry
);

    aes_state_e          state_q, state_d;
    logic [BLOCK_W-1:0]  blk_q, blk_d;
    logic [BLOCK_W-1:0]  pt_q, pt_d;
    logic [KSEL_W-1:0]   sel_key_q, sel_key_d;
    logic [KSEL_W-1:0]   round_q, round_d;
    logic                ry_q, ry_d;

    logic [BLOCK_W-1:0]  isr_c;
    logic [BLOCK_W-1:0]  isb_c;
    logic [BLOCK_W-1:0]  imc_c;

    // Row r of the column-major block rotates right by r byte positions
    always_comb begin
        isr_c = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr_c[127 - 8*(r + 4*c) -: 8] = blk_q[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_isb
        inv_sbox u_inv_sbox (
            .din_i  (blk_q[127 - 8*g -: 8]),
            .dout_o (isb_c[127 - 8*g -: 8])
        );
    end

    always_comb begin
        imc_c = '0;
        for (int c = 0; c < 4; c++) begin
            imc_c[127 - 32*c -: 32] = inv_mix_col(blk_q[127 - 32*c -: 32]);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_IDLE;
            blk_q     <= '0;
            pt_q      <= '0;
            sel_key_q <= '0;
            round_q   <= '0;
            ry_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_q     <= blk_d;
            pt_q      <= pt_d;
            sel_key_q <= sel_key_d;
            round_q   <= round_d;
            ry_q      <= ry_d;
        end
    end

    // Next state and per-state transform select; K10 is applied in INIT as soon as it is selected
    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        pt_d      = pt_q;
        sel_key_d = sel_key_q;
        round_d   = round_q;
        ry_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (En) begin
                    blk_d     = CT;
                    sel_key_d = KSEL_W'(NR);
                    round_d   = KSEL_W'(NR - 1);
                    state_d   = S_INIT;
                end
            end
            S_INIT: begin
                blk_d     = blk_q ^ Key;
                sel_key_d = KSEL_W'(NR - 1);
                state_d   = S_ISR;
            end
            S_ISR: begin
                blk_d   = isr_c;
                state_d = S_ISB;
            end
            S_ISB: begin
                blk_d   = isb_c;
                state_d = S_ARK;
            end
            S_ARK: begin
                blk_d = blk_q ^ Key;
                if (round_q != '0) begin
                    sel_key_d = sel_key_q - KSEL_W'(1);
                    round_d   = round_q - KSEL_W'(1);
                    state_d   = S_IMC;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_IMC: begin
                blk_d   = imc_c;
                state_d = S_ISR;
            end
            S_DONE: begin
                pt_d      = blk_q;
                ry_d      = 1'b1;
                sel_key_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign SelKey = sel_key_q;
    assign PT     = pt_q;
    assign Ry     = ry_q;

endmodule

// File: tb/tb_aes_decryptor.sv
// Directed and loopback bench for aes_decryptor; round keys and the forward
// cipher are modelled here from first principles.
module tb_aes_decryptor;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [47:0]  SEQ_EXP = 48'h0a9876543210;

    logic         Clk;
    logic         Rst;
    logic         En;
    logic [127:0] CT;
    logic [127:0] Key;
    logic [3:0]   SelKey;
    logic [127:0] PT;
    logic         Ry;

    logic [127:0] ks [11];
    logic [7:0]   sbox [256];
    int           n_checks;
    int           n_pass;

    aes_decryptor dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .En     (En),
        .CT     (CT),
        .Key    (Key),
        .SelKey (SelKey),
        .PT     (PT),
        .Ry     (Ry)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign Key = (SelKey <= 4'd10) ? ks[SelKey] : '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from multiplicative inverse plus affine transform
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ ks[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[127 - 8*i -: 8] = sbox[s[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[127 - 8*(rr + 4*c) -: 8] = t[127 - 8*(rr + 4*((c + rr) % 4)) -: 8];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32*c -: 8];
                    a1 = s[119 - 32*c -: 8];
                    a2 = s[111 - 32*c -: 8];
                    a3 = s[103 - 32*c -: 8];
                    s[127 - 32*c -: 32] = {gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
                                           a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
                                           a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
                                           gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
                end
            end
            s = s ^ ks[r];
        end
        return s;
    endfunction

    // Start one block from an idle DUT (called at a negedge); En pulses at poke cycles
    task automatic run_op(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                          input int poke_a, input int poke_b, input bit full,
                          output logic [47:0] seq);
        int           lat;
        int           nry;
        logic [127:0] pt_at;
        logic [3:0]   last_sk;
        lat     = -1;
        nry     = 0;
        pt_at   = '0;
        seq     = '0;
        last_sk = SelKey;
        CT      = ct;
        En      = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge Clk);
            En = (cyc == poke_a) || (cyc == poke_b);
            if (cyc == 3) CT = ~ct;
            if (SelKey != last_sk) begin
                seq     = {seq[43:0], SelKey};
                last_sk = SelKey;
            end
            if (Ry) begin
                nry++;
                if (lat < 0) begin
                    lat   = cyc;
                    pt_at = PT;
                end
            end
            if (!full && lat >= 0) break;
        end
        En = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(42));
        check({tag, "_pt"}, pt_at, exp);
        if (full) begin
            check({tag, "_ry_pulses"}, 128'(nry), 128'(1));
            check({tag, "_pt_held"}, PT, exp);
        end
    endtask

    initial begin
        logic [47:0]  seq;
        logic [127:0] lb_key;
        logic [127:0] lb_pt;
        int           lat;
        n_checks = 0;
        n_pass   = 0;
        Rst      = 1'b0;
        En       = 1'b0;
        CT       = '0;
        build_sbox();
        expand_key(KEY_C1);

        repeat (3) @(negedge Clk);
        check("rst_pt", PT, '0);
        check("rst_ry", 128'(Ry), '0);
        check("rst_selkey", 128'(SelKey), '0);
        Rst = 1'b1;
        @(negedge Clk);

        run_op("c1", CT_C1, PT_C1, 0, 0, 1'b1, seq);
        check("c1_selkey_seq", 128'(seq), 128'(SEQ_EXP));

        expand_key(KEY_B);
        run_op("appb", CT_B, PT_B, 0, 0, 1'b1, seq);

        expand_key(KEY_C1);
        run_op("busy_en", CT_C1, PT_C1, 5, 30, 1'b1, seq);

        // En held high with the two vectors alternating; CT scrambled mid-block
        En = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expand_key((i % 2 == 0) ? KEY_B : KEY_C1);
            CT  = (i % 2 == 0) ? CT_B : CT_C1;
            lat = -1;
            for (int cyc = 1; cyc <= 60 && lat < 0; cyc++) begin
                @(negedge Clk);
                if (cyc == 1) check("b2b_ry_single", 128'(Ry), '0);
                if (cyc == 12) CT = {$urandom, $urandom, $urandom, $urandom};
                if (Ry) lat = cyc;
            end
            check("b2b_period", 128'(lat), 128'(42));
            check("b2b_pt", PT, (i % 2 == 0) ? PT_B : PT_C1);
        end
        En = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset 20 cycles into a block
        expand_key(KEY_C1);
        CT = CT_C1;
        En = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge Clk);
            En = 1'b0;
        end
        Rst = 1'b0;
        #1;
        check("midrst_pt", PT, '0);
        check("midrst_ry", 128'(Ry), '0);
        check("midrst_selkey", 128'(SelKey), '0);
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        run_op("post_rst_c1", CT_C1, PT_C1, 0, 0, 1'b1, seq);

        for (int n = 0; n < 1000; n++) begin
            lb_key = {$urandom, $urandom, $urandom, $urandom};
            lb_pt  = {$urandom, $urandom, $urandom, $urandom};
            expand_key(lb_key);
            run_op("loopback", encrypt(lb_pt), lb_pt, 0, 0, 1'b0, seq);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
